// File: rtl/memtest_pkg.sv
// Shared encodings for the AHB-Lite memory tester: FSM states, pattern codes, bus constants.
// Also holds the pattern seed and LFSR step helpers used by the tester and its pattern generator.
package memtest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WDRAIN,
    ST_DELAY,
    ST_READ,
    ST_RDRAIN,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    PATTERN_ADDR  = 2'd0,
    PATTERN_NADDR = 2'd1,
    PATTERN_WALK  = 2'd2,
    PATTERN_LFSR  = 2'd3
  } pattern_t;

  localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0]  HBURST_SINGLE = 3'b000;

  // Starting value of the generator for a given pass; ~addr keeps the plain address and inverts on output.
  function automatic logic [31:0] pattern_seed(input pattern_t mode, input logic [31:0] base,
                                               input logic [31:0] pass);
    logic [31:0] s;
    case (mode)
      PATTERN_WALK: s = 32'h1 << pass[4:0];
      PATTERN_LFSR: begin
        s = base ^ pass;
        if (s == 32'h0) s = 32'h1;
      end
      default:      s = base;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/memtest_pattern_gen.sv
// Per-beat test pattern source: load() sets seed and mode, step() advances to the next word.
// Output is combinational from the current state; it only moves on load or step, so it holds under wait states.
module memtest_pattern_gen
  import memtest_pkg::*;
#(
  parameter int unsigned ADDR_INCREMENT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  pattern_t    mode,
  input  logic        step,
  output logic [31:0] pat
);

  logic [31:0] value;
  pattern_t    cur_mode;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value    <= '0;
      cur_mode <= PATTERN_ADDR;
    end else if (load) begin
      value    <= seed;
      cur_mode <= mode;
    end else if (step) begin
      case (cur_mode)
        PATTERN_WALK: value <= {value[30:0], value[31]};
        PATTERN_LFSR: value <= lfsr_next(value);
        default:      value <= value + 32'(ADDR_INCREMENT);
      endcase
    end
  end

  assign pat = (cur_mode == PATTERN_NADDR) ? ~value : value;

endmodule

// File: rtl/ahb_lite_mem_tester.sv
// AHB-Lite master that writes a pattern over a memory window, reads it back and counts mismatches/HRESP errors.
// Pipelined single transfers, stalls on HREADY=0; MEMTEST_ERRLOG_EN adds the first-error capture registers.
module ahb_lite_mem_tester
  import memtest_pkg::*;
#(
  parameter int unsigned ADDR_INCREMENT = 4,
  parameter int unsigned WORD_CNT       = 16000,
  parameter int unsigned PASS_CNT       = 0,
  parameter int unsigned DELAY_BITS     = 26,
  parameter logic [2:0]  HSIZE_CFG      = 3'd2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        START,
  input  logic [31:0] STARTADDR,
  input  logic [1:0]  PATTERN_SEL,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  output logic        HSEL,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        BUSY,
  output logic        S_WRITE,
  output logic        S_CHECK,
  output logic        S_SUCCESS,
  output logic        S_FAILED,
  output logic [31:0] ERRCOUNT,
  output logic [7:0]  CHKCOUNT,
  output logic [31:0] FAIL_ADDR,
  output logic [31:0] FAIL_EXP,
  output logic [31:0] FAIL_ACT
);

  localparam logic [31:0] LAST_WORD = 32'(WORD_CNT - 1);
  localparam logic [31:0] LAST_PASS = 32'(PASS_CNT - 1);

  state_t      state, state_nxt;
  logic [31:0] addr;
  logic [31:0] word_idx;
  logic        dp_vld;
  logic [31:0] dp_addr;
  logic [31:0] pass_idx;
  logic [31:0] base;
  pattern_t    mode;
  logic [DELAY_BITS-1:0] delay_cnt;
  logic [31:0] err_cnt;
  logic        pass_err;
  logic        success;
  logic [7:0]  chk_cnt;

  logic        addr_phase, addr_ok, last_addr, dp_done, read_dp;
  logic        err_ev, start_run, start_clr, delay_done, more_pass, pass_end;
  logic        gen_load, write_start;
  logic [31:0] gen_seed;
  pattern_t    gen_mode;
  logic [31:0] pat;

  assign addr_phase = (state == ST_WRITE) || (state == ST_READ);
  assign addr_ok    = addr_phase && HREADY;
  assign last_addr  = addr_ok && (word_idx == LAST_WORD);
  assign dp_done    = dp_vld && HREADY;
  assign read_dp    = (state == ST_READ) || (state == ST_RDRAIN);
  // A two-cycle error response is only counted on its HREADY=1 cycle.
  assign err_ev     = dp_done && (HRESP || (read_dp && (HRDATA != pat)));
  assign start_run  = START && (state == ST_IDLE);
  assign start_clr  = START && ((state == ST_IDLE) || (state == ST_DONE));
  assign delay_done = &delay_cnt;
  assign more_pass  = (PASS_CNT == 0) || (pass_idx != LAST_PASS);
  assign pass_end   = (state == ST_RDRAIN) && dp_done;
  assign write_start = gen_load && (state != ST_DELAY);

  always_comb begin
    state_nxt = state;
    gen_load  = 1'b0;
    gen_mode  = mode;
    gen_seed  = pattern_seed(mode, base, pass_idx);
    case (state)
      ST_IDLE: if (START) begin
        state_nxt = ST_WRITE;
        gen_load  = 1'b1;
        gen_mode  = pattern_t'(PATTERN_SEL);
        gen_seed  = pattern_seed(pattern_t'(PATTERN_SEL), STARTADDR, 32'd0);
      end
      ST_WRITE:  if (last_addr) state_nxt = ST_WDRAIN;
      ST_WDRAIN: if (dp_done) state_nxt = ST_DELAY;
      ST_DELAY: if (delay_done) begin
        state_nxt = ST_READ;
        gen_load  = 1'b1;
      end
      ST_READ:   if (last_addr) state_nxt = ST_RDRAIN;
      ST_RDRAIN: if (dp_done) begin
        if (more_pass) begin
          state_nxt = ST_WRITE;
          gen_load  = 1'b1;
          gen_seed  = pattern_seed(mode, base, pass_idx + 32'd1);
        end else begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE:   if (START) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      addr      <= '0;
      word_idx  <= '0;
      dp_vld    <= 1'b0;
      dp_addr   <= '0;
      pass_idx  <= '0;
      base      <= '0;
      mode      <= PATTERN_ADDR;
      delay_cnt <= '0;
      err_cnt   <= '0;
      pass_err  <= 1'b0;
      success   <= 1'b0;
      chk_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (start_run) begin
        base     <= STARTADDR;
        mode     <= pattern_t'(PATTERN_SEL);
        pass_idx <= '0;
      end else if (pass_end && more_pass) begin
        pass_idx <= pass_idx + 32'd1;
      end

      if (gen_load) begin
        addr     <= start_run ? STARTADDR : base;
        word_idx <= '0;
      end else if (addr_ok) begin
        addr     <= addr + 32'(ADDR_INCREMENT);
        word_idx <= word_idx + 32'd1;
      end

      // Data phase of the accepted address overlaps the next address phase.
      if (addr_ok) begin
        dp_vld  <= 1'b1;
        dp_addr <= addr;
      end else if (dp_done) begin
        dp_vld  <= 1'b0;
      end

      delay_cnt <= (state == ST_DELAY) ? delay_cnt + 1'b1 : '0;

      if (pass_end) chk_cnt <= chk_cnt + 8'd1;

      if (start_clr)                         err_cnt <= '0;
      else if (err_ev && (err_cnt != '1))    err_cnt <= err_cnt + 32'd1;

      if (write_start) pass_err <= 1'b0;
      else if (err_ev) pass_err <= 1'b1;

      if (start_clr || err_ev)      success <= 1'b0;
      else if (pass_end && !pass_err) success <= 1'b1;
    end
  end

  memtest_pattern_gen #(
    .ADDR_INCREMENT(ADDR_INCREMENT)
  ) u_pattern_gen (
    .clk  (HCLK),
    .rst_n(HRESETn),
    .load (gen_load),
    .seed (gen_seed),
    .mode (gen_mode),
    .step (dp_done),
    .pat  (pat)
  );

  assign HTRANS    = addr_phase ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HSEL      = addr_phase;
  assign HADDR     = addr;
  assign HWRITE    = (state == ST_WRITE);
  assign HSIZE     = addr_phase ? HSIZE_CFG : 3'd0;
  assign HBURST    = HBURST_SINGLE;
  assign HWDATA    = (dp_vld && S_WRITE) ? pat : '0;

  assign S_WRITE   = (state == ST_WRITE) || (state == ST_WDRAIN);
  assign S_CHECK   = read_dp;
  assign BUSY      = (state != ST_IDLE) && (state != ST_DONE);
  assign S_SUCCESS = success;
  assign S_FAILED  = (err_cnt != '0);
  assign ERRCOUNT  = err_cnt;
  assign CHKCOUNT  = chk_cnt;

`ifdef MEMTEST_ERRLOG_EN
  logic logged;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      logged    <= 1'b0;
      FAIL_ADDR <= '0;
      FAIL_EXP  <= '0;
      FAIL_ACT  <= '0;
    end else if (start_clr) begin
      logged    <= 1'b0;
      FAIL_ADDR <= '0;
      FAIL_EXP  <= '0;
      FAIL_ACT  <= '0;
    end else if (err_ev && !logged) begin
      logged    <= 1'b1;
      FAIL_ADDR <= dp_addr;
      FAIL_EXP  <= pat;
      FAIL_ACT  <= read_dp ? HRDATA : 32'd0;
    end
  end
`else
  assign FAIL_ADDR = '0;
  assign FAIL_EXP  = '0;
  assign FAIL_ACT  = '0;
`endif

endmodule

// File: tb/tb_ahb_lite_mem_tester.sv
// Bench for ahb_lite_mem_tester: two instances (4-word single pass, 33-word two-pass walking-one)
// against behavioural slaves with fault injection; table of directed runs plus reset/multi-pass sequences.
module tb_ahb_lite_mem_tester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // Instance 1: WORD_CNT=4, single pass
  logic        start1;
  logic [31:0] saddr1;
  logic [1:0]  sel1;
  logic [31:0] haddr1, hwdata1, hrdata1;
  logic [2:0]  hburst1, hsize1;
  logic [1:0]  htrans1;
  logic        hwrite1, hsel1, hready1, hresp1;
  logic        busy1, sw1, sc1, ss1, sf1;
  logic [31:0] errc1, fa1, fe1, fx1;
  logic [7:0]  chk1;

  // Instance 2: WORD_CNT=33, two passes
  logic        start2;
  logic [31:0] saddr2;
  logic [1:0]  sel2;
  logic [31:0] haddr2, hwdata2, hrdata2;
  logic [2:0]  hburst2, hsize2;
  logic [1:0]  htrans2;
  logic        hwrite2, hsel2, hready2, hresp2;
  logic        busy2, sw2, sc2, ss2, sf2;
  logic [31:0] errc2, fa2, fe2, fx2;
  logic [7:0]  chk2;

  ahb_lite_mem_tester #(.ADDR_INCREMENT(4), .WORD_CNT(4), .PASS_CNT(1), .DELAY_BITS(2), .HSIZE_CFG(3'd2)) dut1 (
    .HCLK(clk), .HRESETn(rst_n), .START(start1), .STARTADDR(saddr1), .PATTERN_SEL(sel1),
    .HADDR(haddr1), .HBURST(hburst1), .HSIZE(hsize1), .HTRANS(htrans1), .HWDATA(hwdata1),
    .HWRITE(hwrite1), .HSEL(hsel1), .HRDATA(hrdata1), .HREADY(hready1), .HRESP(hresp1),
    .BUSY(busy1), .S_WRITE(sw1), .S_CHECK(sc1), .S_SUCCESS(ss1), .S_FAILED(sf1),
    .ERRCOUNT(errc1), .CHKCOUNT(chk1), .FAIL_ADDR(fa1), .FAIL_EXP(fe1), .FAIL_ACT(fx1));

  ahb_lite_mem_tester #(.ADDR_INCREMENT(4), .WORD_CNT(33), .PASS_CNT(2), .DELAY_BITS(2), .HSIZE_CFG(3'd2)) dut2 (
    .HCLK(clk), .HRESETn(rst_n), .START(start2), .STARTADDR(saddr2), .PATTERN_SEL(sel2),
    .HADDR(haddr2), .HBURST(hburst2), .HSIZE(hsize2), .HTRANS(htrans2), .HWDATA(hwdata2),
    .HWRITE(hwrite2), .HSEL(hsel2), .HRDATA(hrdata2), .HREADY(hready2), .HRESP(hresp2),
    .BUSY(busy2), .S_WRITE(sw2), .S_CHECK(sc2), .S_SUCCESS(ss2), .S_FAILED(sf2),
    .ERRCOUNT(errc2), .CHKCOUNT(chk2), .FAIL_ADDR(fa2), .FAIL_EXP(fe2), .FAIL_ACT(fx2));

  // Slave 1: memory with wait states, read bit flip and two-cycle write error injection
  int          ws = 0;
  logic [31:0] flip_addr, err_addr;
  logic        log_clr = 1'b0;
  logic [31:0] mem1 [0:255];
  logic        s1_v, s1_w, s1_err, s1_err2;
  logic [31:0] s1_a;
  int          s1_wc;
  logic [31:0] wa1 [0:15];
  logic [31:0] wd1 [0:15];
  int          wn1 = 0, rn1 = 0;

  assign hready1 = !s1_v || (s1_err ? s1_err2 : (s1_wc == 0));
  assign hresp1  = s1_v && s1_err;
  assign hrdata1 = (s1_v && !s1_w) ? (mem1[s1_a[9:2]] ^ {31'd0, s1_a == flip_addr}) : 32'd0;

  always @(posedge clk) begin
    if (!rst_n) begin
      s1_v <= 1'b0; s1_w <= 1'b0; s1_a <= '0; s1_err <= 1'b0; s1_err2 <= 1'b0; s1_wc <= 0;
    end else begin
      if (s1_v && hready1) begin
        if (s1_w) begin
          mem1[s1_a[9:2]] <= hwdata1;
          if (wn1 < 16) begin wa1[wn1] <= s1_a; wd1[wn1] <= hwdata1; end
          wn1 <= wn1 + 1;
        end else begin
          rn1 <= rn1 + 1;
        end
      end
      if (hready1) begin
        s1_v    <= (htrans1 == 2'b10);
        s1_a    <= haddr1;
        s1_w    <= hwrite1;
        s1_wc   <= ws;
        s1_err  <= (htrans1 == 2'b10) && hwrite1 && (haddr1 == err_addr);
        s1_err2 <= 1'b0;
      end else begin
        if (s1_wc > 0) s1_wc <= s1_wc - 1;
        s1_err2 <= 1'b1;
      end
    end
    if (log_clr) begin wn1 <= 0; rn1 <= 0; end
  end

  // Slave 2: zero-wait memory, logs every write datum
  logic [31:0] mem2 [0:63];
  logic        s2_v, s2_w;
  logic [31:0] s2_a;
  logic [31:0] wd2 [0:127];
  int          wn2 = 0;

  assign hready2 = 1'b1;
  assign hresp2  = 1'b0;
  assign hrdata2 = (s2_v && !s2_w) ? mem2[s2_a[7:2]] : 32'd0;

  always @(posedge clk) begin
    if (!rst_n) begin
      s2_v <= 1'b0; s2_w <= 1'b0; s2_a <= '0;
    end else begin
      if (s2_v && s2_w) begin
        mem2[s2_a[7:2]] <= hwdata2;
        if (wn2 < 128) wd2[wn2] <= hwdata2;
        wn2 <= wn2 + 1;
      end
      s2_v <= (htrans2 == 2'b10);
      s2_a <= haddr2;
      s2_w <= hwrite2;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Address and write data must not move across a cycle with HREADY=0
  logic [31:0] h_addr, h_wdata;
  logic        h_stall = 1'b0;
  always @(negedge clk) begin
    if (rst_n && h_stall) begin
      check("hold_haddr", haddr1, h_addr);
      check("hold_hwdata", hwdata1, h_wdata);
    end
    h_addr  <= haddr1;
    h_wdata <= hwdata1;
    h_stall <= rst_n && !hready1;
  end

  task automatic pulse_start1();
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
  endtask

  task automatic wait_idle1(input string name);
    int n = 0;
    while (busy1 && n < 3000) begin @(negedge clk); n++; end
    if (busy1) begin
      checks++; errors++;
      $display("FAIL %s timeout busy=%0b required=0", name, busy1);
    end
  endtask

  typedef struct {
    logic [31:0] start;
    logic [1:0]  sel;
    int          ws;
    logic [31:0] flip;
    logic [31:0] erra;
    logic [31:0] exp_err;
    logic        exp_succ;
    logic [31:0] exp_wd0;
    logic [31:0] exp_wd3;
    logic [31:0] exp_fa;
    logic [31:0] exp_fe;
    logic [31:0] exp_fx;
  } vec_t;

  localparam logic [31:0] NONE = 32'hFFFF_FFF0;
  vec_t       vecs [0:7];
  logic [7:0] exp_chk;

  initial begin
    vecs[0] = '{32'h100, 2'd0, 0, NONE,   NONE,   32'd0, 1'b1, 32'h100,       32'h10C,       32'h0,   32'h0,         32'h0};
    vecs[1] = '{32'h100, 2'd0, 0, 32'h108, NONE,  32'd1, 1'b0, 32'h100,       32'h10C,       32'h108, 32'h108,       32'h109};
    vecs[2] = '{32'h100, 2'd0, 3, NONE,   NONE,   32'd0, 1'b1, 32'h100,       32'h10C,       32'h0,   32'h0,         32'h0};
    vecs[3] = '{32'h100, 2'd0, 0, NONE,   32'h104, 32'd1, 1'b0, 32'h100,      32'h10C,       32'h104, 32'h104,       32'h0};
    vecs[4] = '{32'h100, 2'd1, 0, 32'h10C, NONE,  32'd1, 1'b0, 32'hFFFF_FEFF, 32'hFFFF_FEF3, 32'h10C, 32'hFFFF_FEF3, 32'hFFFF_FEF2};
    vecs[5] = '{32'h100, 2'd2, 0, NONE,   NONE,   32'd0, 1'b1, 32'h1,         32'h8,         32'h0,   32'h0,         32'h0};
    vecs[6] = '{32'h100, 2'd3, 1, NONE,   NONE,   32'd0, 1'b1, 32'h100,       32'h20,        32'h0,   32'h0,         32'h0};
    vecs[7] = '{32'h0,   2'd3, 0, NONE,   NONE,   32'd0, 1'b1, 32'h1,         32'h6018_0001, 32'h0,   32'h0,         32'h0};

    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
    saddr1 = 32'h100; sel1 = 2'd0; saddr2 = 32'h0; sel2 = 2'd2;
    flip_addr = NONE; err_addr = NONE;
    exp_chk = 8'd0;
    repeat (3) @(negedge clk);

    check("rst_htrans", {30'd0, htrans1}, 32'd0);
    check("rst_hburst", {29'd0, hburst1}, 32'd0);
    check("rst_haddr", haddr1, 32'd0);
    check("rst_hwdata", hwdata1, 32'd0);
    check("rst_status", {25'd0, busy1, sw1, sc1, ss1, sf1, hsel1, hwrite1}, 32'd0);
    check("rst_errcount", errc1, 32'd0);
    check("rst_chkcount", {24'd0, chk1}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      saddr1 = vecs[v].start; sel1 = vecs[v].sel; ws = vecs[v].ws;
      flip_addr = vecs[v].flip; err_addr = vecs[v].erra;
      log_clr = 1'b1;
      @(negedge clk); log_clr = 1'b0;
      pulse_start1();
      check($sformatf("v%0d_busy_start", v), {30'd0, busy1, sw1}, 32'd3);
      wait_idle1($sformatf("v%0d_run", v));
      exp_chk = exp_chk + 8'd1;
      check($sformatf("v%0d_errcount", v), errc1, vecs[v].exp_err);
      check($sformatf("v%0d_success", v), {31'd0, ss1}, {31'd0, vecs[v].exp_succ});
      check($sformatf("v%0d_failed", v), {31'd0, sf1}, {31'd0, vecs[v].exp_err != 0});
      check($sformatf("v%0d_chkcount", v), {24'd0, chk1}, {24'd0, exp_chk});
      check($sformatf("v%0d_writes", v), wn1, 32'd4);
      check($sformatf("v%0d_reads", v), rn1, 32'd4);
      check($sformatf("v%0d_wdata0", v), wd1[0], vecs[v].exp_wd0);
      check($sformatf("v%0d_wdata3", v), wd1[3], vecs[v].exp_wd3);
      check($sformatf("v%0d_waddr3", v), wa1[3], vecs[v].start + 32'd12);
`ifdef MEMTEST_ERRLOG_EN
      check($sformatf("v%0d_fail_addr", v), fa1, vecs[v].exp_fa);
      check($sformatf("v%0d_fail_exp", v), fe1, vecs[v].exp_fe);
      check($sformatf("v%0d_fail_act", v), fx1, vecs[v].exp_fx);
`else
      check($sformatf("v%0d_fail_tied", v), fa1 | fe1 | fx1, 32'd0);
`endif
      // START in DONE returns to IDLE and clears the error state
      pulse_start1();
      check($sformatf("v%0d_clear", v), {28'd0, busy1, ss1, sf1, errc1 != 0}, 32'd0);
    end

    // Walking one over 33 words and two passes
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int n = 0; n < 3000 && busy2; n++) @(negedge clk);
    check("mp_busy_end", {31'd0, busy2}, 32'd0);
    check("mp_chkcount", {24'd0, chk2}, 32'd2);
    check("mp_errcount", errc2, 32'd0);
    check("mp_success", {31'd0, ss2}, 32'd1);
    check("mp_writes", wn2, 32'd66);
    check("mp_p0_w0", wd2[0], 32'h1);
    check("mp_p0_w31", wd2[31], 32'h8000_0000);
    check("mp_p0_w32", wd2[32], 32'h1);
    check("mp_p1_w0", wd2[33], 32'h2);
    check("mp_p1_w31", wd2[64], 32'h1);
    check("mp_p1_w32", wd2[65], 32'h2);

    // Reset during read beat 2, then a clean rerun
    saddr1 = 32'h100; sel1 = 2'd0; ws = 0; flip_addr = NONE; err_addr = NONE;
    pulse_start1();
    begin
      int n = 0;
      while (!(htrans1 == 2'b10 && !hwrite1 && haddr1 == 32'h108) && n < 200) begin
        @(negedge clk); n++;
      end
      check("rr_reach_read2", haddr1, 32'h108);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("rr_htrans", {30'd0, htrans1}, 32'd0);
    check("rr_status", {27'd0, busy1, sw1, sc1, ss1, sf1}, 32'd0);
    check("rr_chkcount", {24'd0, chk1}, 32'd0);
    check("rr_errcount", errc1, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start1();
    wait_idle1("rr_rerun");
    check("rr_rerun_err", errc1, 32'd0);
    check("rr_rerun_success", {31'd0, ss1}, 32'd1);
    check("rr_rerun_chkcount", {24'd0, chk1}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
